id_ex_pipe_reg: RTL

- Clocked, parametrised ID/EX pipeline register for the five-stage MIPS datapath.
- Sits between the decode stage (control unit, register file, sign-extend) and the execute stage (ALU, ALU control, destination mux).
- Adds per-stage hold (stall), flush, a valid bit, built-in load-use hazard detection with bubble insertion, and a saturating bubble counter for performance analysis.

---
 rtl/id_ex_pipe_reg.sv | 118 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the five-stage MIPS datapath: holds decode results for
// execute, with stall/flush, a valid bit, load-use bubble insertion and a bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [1:0]           ctlwb_out,
  input  logic [2:0]           ctlm_out,
  input  logic [ALUOP_W+1:0]   ctlex_out,
  input  logic [DATA_W-1:0]    npc,
  input  logic [DATA_W-1:0]    readdat1,
  input  logic [DATA_W-1:0]    readdat2,
  input  logic [DATA_W-1:0]    signext_out,
  input  logic [REG_W-1:0]     instr_2521,
  input  logic [REG_W-1:0]     instr_2016,
  input  logic [REG_W-1:0]     instr_1511,
  output logic [1:0]           wb_ctlout,
  output logic [2:0]           m_ctlout,
  output logic                 regdst,
  output logic                 alusrc,
  output logic [ALUOP_W-1:0]   aluop,
  output logic [DATA_W-1:0]    npcout,
  output logic [DATA_W-1:0]    rdata1out,
  output logic [DATA_W-1:0]    rdata2out,
  output logic [DATA_W-1:0]    s_extendout,
  output logic [REG_W-1:0]     instrout_2016,
  output logic [REG_W-1:0]     instrout_1511,
  output logic                 valid_out,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_e;

  act_e act;

  // A load in EX whose destination is read by the ID instruction; $zero never conflicts.
  assign hazard_stall = valid_out & m_ctlout[1] & valid_in & (instrout_2016 != '0) &
                        ((instrout_2016 == instr_2521) | (instrout_2016 == instr_2016));

  always_comb begin
    // NOTE: default first so every path assigns act and no latch is inferred.
    act = ACT_LOAD;
    if (flush)             act = ACT_BUBBLE;
    else if (stall)        act = ACT_HOLD;
    else if (hazard_stall) act = ACT_BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctlout     <= '0;
      m_ctlout      <= '0;
      regdst        <= 1'b0;
      alusrc        <= 1'b0;
      aluop         <= '0;
      npcout        <= '0;
      rdata1out     <= '0;
      rdata2out     <= '0;
      s_extendout   <= '0;
      instrout_2016 <= '0;
      instrout_1511 <= '0;
      valid_out     <= 1'b0;
    end else begin
      unique case (act)
        ACT_BUBBLE: begin
          wb_ctlout     <= '0;
          m_ctlout      <= '0;
          regdst        <= 1'b0;
          alusrc        <= 1'b0;
          aluop         <= '0;
          npcout        <= '0;
          rdata1out     <= '0;
          rdata2out     <= '0;
          s_extendout   <= '0;
          instrout_2016 <= '0;
          instrout_1511 <= '0;
          valid_out     <= 1'b0;
        end
        ACT_LOAD: begin
          wb_ctlout     <= ctlwb_out;
          m_ctlout      <= ctlm_out;
          regdst        <= ctlex_out[ALUOP_W+1];
          aluop         <= ctlex_out[ALUOP_W:1];
          alusrc        <= ctlex_out[0];
          npcout        <= npc;
          rdata1out     <= readdat1;
          rdata2out     <= readdat2;
          s_extendout   <= signext_out;
          instrout_2016 <= instr_2016;
          instrout_1511 <= instr_1511;
          valid_out     <= valid_in;
        end
        default: ;
      endcase
    end
  end

  // Saturating: once all ones the count sticks until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (act == ACT_BUBBLE && bubble_cnt != '1)
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

endmodule
